// File: rtl/spi_slave_core_pkg.sv
// Shared definitions for the SPI responder: default character length,
// FSM state encodings and the fill pattern loaded on a transmit underrun.
`ifndef SPI_CHAR_LEN
`define SPI_CHAR_LEN 8
`endif

package spi_slave_core_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Every bit of a character loaded from an empty holding buffer.
  localparam logic UNDERRUN_FILL_BIT = 1'b0;

endpackage

// File: rtl/spi_sync.sv
// N-flop bit synchronizer with a configurable reset level, used to bring
// the asynchronous SPI bus pins into the system clock domain.
module spi_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  // Shift the pin value through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments make every flop in the chain take the
    // previous stage's old value, so the chain really is N flops deep.
    if (!rst_n) sync_q <= {N{RST_VAL}};
    else        sync_q <= {sync_q[N-2:0], d_i};
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/spi_slave_core.sv
// SPI responder core: oversamples SCLK/CS/MOSI on sys_clk, supports all four
// CPOL/CPHA modes and exchanges CHAR_LEN-bit characters with the host.
// Optional feature: define SPI_SLAVE_LSB_FIRST_EN to add the LSB input that
// selects LSB-first shifting; without it the core is MSB-first only.
`ifndef SPI_CHAR_LEN
`define SPI_CHAR_LEN 8
`endif

module spi_slave_core
  import spi_slave_core_pkg::*;
#(
  parameter int CHAR_LEN    = `SPI_CHAR_LEN,
  parameter int SYNC_STAGES = 2
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                CPOL,
  input  logic                CPHA,
  input  logic                SCLK,
  input  logic                CS,
  input  logic                MOSI,
`ifdef SPI_SLAVE_LSB_FIRST_EN
  input  logic                LSB,
`endif
  output logic                MISO,
  output logic                MISO_OE,
  input  logic [CHAR_LEN-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [CHAR_LEN-1:0] rx_data,
  output logic                rx_valid,
  output logic                underrun,
  output logic                busy
);

  localparam int            CW       = $clog2(CHAR_LEN);
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAR_LEN - 1);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_q, cs_q;
  state_e state_q, state_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CHAR_LEN-2:0] rx_shift_q, rx_shift_d;
  logic [CHAR_LEN-1:0] tx_shift_q, tx_shift_d;
  logic [CHAR_LEN-1:0] rx_data_q, rx_data_d;
  logic [CHAR_LEN-1:0] buf_q, buf_d;
  logic rx_valid_q, rx_valid_d;
  logic underrun_q, underrun_d;
  logic full_q, full_d;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge, cs_fall, cs_rise;
  logic lsb_first, load, write;
  logic [CHAR_LEN-1:0] rx_word, tx_next;

  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(sys_clk), .rst_n(rst_n), .d_i(SCLK), .q_o(sclk_s));
  // CS resets high so the core comes out of reset deselected.
  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(sys_clk), .rst_n(rst_n), .d_i(CS), .q_o(cs_s));
  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(sys_clk), .rst_n(rst_n), .d_i(MOSI), .q_o(mosi_s));

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign lsb_first = LSB;
`else
  assign lsb_first = 1'b0;
`endif

  assign sclk_rise   = sclk_s & ~sclk_q;
  assign sclk_fall   = ~sclk_s & sclk_q;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = ~cs_s & cs_q;
  assign cs_rise     = cs_s & ~cs_q;

  // The rx shifter keeps the CHAR_LEN-1 earlier bits; the new bit completes the word.
  assign rx_word = lsb_first ? {mosi_s, rx_shift_q} : {rx_shift_q, mosi_s};
  assign tx_next = lsb_first ? {1'b0, tx_shift_q[CHAR_LEN-1:1]}
                             : {tx_shift_q[CHAR_LEN-2:0], 1'b0};

  assign write = tx_valid & ~full_q;

  // Next-state logic for the FSM, shifters, bit counter and holding buffer.
  always_comb begin
    // NOTE: every target gets a default before any branch so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    buf_d      = buf_q;
    load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d    = ST_ACTIVE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          load       = ~CPHA;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          // Abandon any partial character; an SCLK edge this cycle is ignored.
          state_d    = ST_IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_shift_d = '0;
        end else if (sample_edge) begin
          rx_shift_d = lsb_first ? rx_word[CHAR_LEN-1:1] : rx_word[CHAR_LEN-2:0];
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else if (shift_edge) begin
          // The first shift edge of a character (bit_cnt still 0) loads it.
          if (bit_cnt_q == '0) load = 1'b1;
          else                 tx_shift_d = tx_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      if (full_q) begin
        tx_shift_d = buf_q;
      end else begin
        tx_shift_d = {CHAR_LEN{UNDERRUN_FILL_BIT}};
        underrun_d = 1'b1;
      end
    end

    // A write alongside an empty-buffer load stays in the buffer.
    full_d = write | (full_q & ~load);
    if (write) buf_d = tx_data;
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      // NOTE: the buffer data is reset too; it is a plain register, not a
      // memory array, and a known value keeps MISO deterministic.
      buf_q      <= '0;
      full_q     <= 1'b0;
    end else begin
      sclk_q     <= sclk_s;
      cs_q       <= cs_s;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
    end
  end

  assign MISO_OE  = ~cs_q;
  assign MISO     = ~cs_q & (lsb_first ? tx_shift_q[0] : tx_shift_q[CHAR_LEN-1]);
  assign tx_ready = ~full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign underrun = underrun_q;
  assign busy     = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: acts as SPI master and host, with
// expected values worked out by hand from the transfer patterns.
`timescale 1ns/1ps
module tb_spi_slave_core;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       CPOL = 1'b0, CPHA = 1'b0, SCLK = 1'b0, CS = 1'b1, MOSI = 1'b0;
  logic       MISO, MISO_OE;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, underrun, busy;
  logic       lsb_mode = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_cnt  = 0;
  int ur_cnt  = 0;
  logic [7:0] rx_hist [64];

  always #5 sys_clk = ~sys_clk;

  spi_slave_core #(.CHAR_LEN(8), .SYNC_STAGES(2)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .CPOL    (CPOL),
    .CPHA    (CPHA),
    .SCLK    (SCLK),
    .CS      (CS),
    .MOSI    (MOSI),
`ifdef SPI_SLAVE_LSB_FIRST_EN
    .LSB     (lsb_mode),
`endif
    .MISO    (MISO),
    .MISO_OE (MISO_OE),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .underrun(underrun),
    .busy    (busy)
  );

  // Log receive and underrun pulses away from the active edge.
  always @(negedge sys_clk) begin
    if (rx_valid) begin
      if (rx_cnt < 64) rx_hist[rx_cnt] = rx_data;
      rx_cnt++;
    end
    if (underrun) ur_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Host write into the holding buffer, bounded wait for tx_ready.
  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (!tx_ready && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    check("push_ready", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
  endtask

  task automatic cs_low();
    CS = 1'b0;
    #60;
  endtask

  task automatic cs_high();
    CS = 1'b1;
    #60;
  endtask

  // Master side of nbits SCLK cycles; each SCLK phase lasts 4 sys_clk periods.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = lsb_mode ? i : 7 - i;
      if (!CPHA) begin
        MOSI = mo[idx];
        #40;
        SCLK = ~CPOL;
        mi[idx] = MISO;
        #40;
        SCLK = CPOL;
      end else begin
        SCLK = ~CPOL;
        MOSI = mo[idx];
        #40;
        SCLK = CPOL;
        mi[idx] = MISO;
        #40;
      end
    end
    if (!CPHA) #40;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mi, m1, m2;
    logic [1:0] m;
    int rb, ub;

    // Reset values
    #42;
    check("rst_miso",     {31'd0, MISO},     32'd0);
    check("rst_miso_oe",  {31'd0, MISO_OE},  32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_data",  {24'd0, rx_data},  32'h00);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    rst_n = 1'b1;
    #60;

    // Mode 0 single character: TX 0xA5, RX 0x3C
    push(8'hA5);
    check("m0_tx_ready_low", {31'd0, tx_ready}, 32'd0);
    cs_low();
    check("m0_busy",    {31'd0, busy},    32'd1);
    check("m0_miso_oe", {31'd0, MISO_OE}, 32'd1);
    rb = rx_cnt;
    xfer(8'h3C, 8, mi);
    #100;
    check("m0_miso_stream", {24'd0, mi}, 32'hA5);
    check("m0_rx_pulses",   rx_cnt - rb, 32'd1);
    check("m0_rx_data",     {24'd0, rx_data}, 32'h3C);
    check("m0_tx_ready",    {31'd0, tx_ready}, 32'd1);
    cs_high();
    check("m0_idle", {31'd0, busy}, 32'd0);

    // Modes 1..3, two characters per CS window
    for (int k = 1; k <= 3; k++) begin
      m = 2'(k);
      CPOL = m[1];
      CPHA = m[0];
      SCLK = m[1];
      #80;
      rb = rx_cnt;
      ub = ur_cnt;
      push(8'h81);
      cs_low();
      fork
        xfer(8'hF0, 8, m1);
        push(8'h7E);
      join
      if (!CPHA) begin
        // Keeps the load at the final trailing edge from underrunning.
        fork
          xfer(8'h0F, 8, m2);
          push(8'hFF);
        join
      end else begin
        xfer(8'h0F, 8, m2);
      end
      #100;
      check($sformatf("m%0d_tx0", k), {24'd0, m1}, 32'h81);
      check($sformatf("m%0d_tx1", k), {24'd0, m2}, 32'h7E);
      check($sformatf("m%0d_rx_pulses", k), rx_cnt - rb, 32'd2);
      check($sformatf("m%0d_rx0", k), {24'd0, rx_hist[rb]},   32'hF0);
      check($sformatf("m%0d_rx1", k), {24'd0, rx_hist[rb+1]}, 32'h0F);
      check($sformatf("m%0d_underrun", k), ur_cnt - ub, 32'd0);
      cs_high();
      check($sformatf("m%0d_tx_ready", k), {31'd0, tx_ready}, 32'd1);
    end

    // Empty buffer in mode 1: one underrun, zero MISO, RX still captured
    CPOL = 1'b0; CPHA = 1'b1; SCLK = 1'b0;
    #80;
    rb = rx_cnt;
    ub = ur_cnt;
    cs_low();
    xfer(8'h96, 8, mi);
    #100;
    check("ur_pulses",  ur_cnt - ub, 32'd1);
    check("ur_miso",    {24'd0, mi}, 32'h00);
    check("ur_rx_data", {24'd0, rx_data}, 32'h96);
    cs_high();

    // CS rises after 5 bits, then a full 0x55 transfer in mode 0
    CPOL = 1'b0; CPHA = 1'b0; SCLK = 1'b0;
    #80;
    rb = rx_cnt;
    cs_low();
    xfer(8'hFF, 5, mi);
    #40;
    cs_high();
    check("abort_rx_pulses", rx_cnt - rb, 32'd0);
    check("abort_busy",      {31'd0, busy}, 32'd0);
    rb = rx_cnt;
    cs_low();
    xfer(8'h55, 8, mi);
    #100;
    check("after_abort_pulses", rx_cnt - rb, 32'd1);
    check("after_abort_rx",     {24'd0, rx_data}, 32'h55);
    cs_high();

    // Reset asserted mid-character
    push(8'h5A);
    cs_low();
    push(8'h66);
    xfer(8'hAA, 4, mi);
    rst_n = 1'b0;
    #1;
    check("mid_rst_miso",     {31'd0, MISO},     32'd0);
    check("mid_rst_miso_oe",  {31'd0, MISO_OE},  32'd0);
    check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("mid_rst_rx_data",  {24'd0, rx_data},  32'h00);
    check("mid_rst_busy",     {31'd0, busy},     32'd0);
    CS = 1'b1;
    SCLK = 1'b0;
    #20;
    rst_n = 1'b1;
    #60;
    rb = rx_cnt;
    push(8'h24);
    cs_low();
    xfer(8'hC3, 8, mi);
    #100;
    check("post_rst_pulses", rx_cnt - rb, 32'd1);
    check("post_rst_rx",     {24'd0, rx_data}, 32'hC3);
    check("post_rst_tx",     {24'd0, mi}, 32'h24);
    cs_high();

`ifdef SPI_SLAVE_LSB_FIRST_EN
    // LSB-first: TX 0x01 leads with a 1, MOSI 1,0,0,... assembles 0x01
    lsb_mode = 1'b1;
    #40;
    push(8'h01);
    cs_low();
    xfer(8'h01, 8, mi);
    #100;
    check("lsb_first_miso_bit", {31'd0, mi[0]}, 32'd1);
    check("lsb_tx",             {24'd0, mi}, 32'h01);
    check("lsb_rx",             {24'd0, rx_data}, 32'h01);
    cs_high();
    lsb_mode = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
